// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Two-requester round-robin arbiter in front of a single-port data RAM.
// Port 0 is the CPU load/store path. Port 1 is a secondary master, such as a
// loader or a debug/DMA engine. Each transaction is accepted with a one-cycle
// gnt pulse. The arbiter then drives one RAM access cycle. For a read, it waits
// out the RAM read latency, captures the data into that port's rdata register
// and pulses that port's rvalid. Every output comes straight from a register.
//
// Ports:
//   clk_main, reset              clock (rising edge), async active-high reset
//   reqN, weN, addrN, wdataN     requester N command, held stable until gntN
//   gntN                         one-cycle pulse: request N accepted
//   rvalidN, rdataN              one-cycle read-valid pulse, held read data
//   ram_en, ram_we               RAM enable / write enable (ACCESS cycle only)
//   ram_addr, ram_wdata          RAM address / write data (hold last value)
//   ram_rdata                    RAM read data, valid READ_LAT cycles after en
//   busy                         high whenever the arbiter is not idle

module ram_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // WAIT lasts READ_LAT-1 cycles. The counter is loaded with one less than
  // that, so the WAIT state exits when the counter reaches zero.
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t              r_state;
  logic                r_last;      // last port served: 1'b0 = port 0, 1'b1 = port 1
  logic                r_op_we;     // the accepted transaction is a write
  logic [1:0]          r_cnt;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_busy;

  logic                w_any;
  logic                w_win1;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Port 1 wins when it is the only requester. It also wins a tie when
  // port 0 was the last port served.
  assign w_any       = req0 | req1;
  assign w_win1      = req1 & (~req0 | ~r_last);
  assign w_sel_we    = w_win1 ? we1    : we0;
  assign w_sel_addr  = w_win1 ? addr1  : addr0;
  assign w_sel_wdata = w_win1 ? wdata1 : wdata0;

  // Arbitration FSM. All outputs are updated in this block.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_op_we     <= 1'b0;
      r_cnt       <= 2'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= {DATA_W{1'b0}};
      r_rdata1    <= {DATA_W{1'b0}};
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wdata <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      // Pulse outputs and the RAM strobes return to 0 unless a state sets them.
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_ram_en  <= 1'b0;
      r_ram_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last      <= w_win1;
            r_op_we     <= w_sel_we;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_gnt0      <= ~w_win1;
            r_gnt1      <= w_win1;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (r_op_we) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (READ_LAT > 1) begin
            r_cnt   <= WAIT_INIT;
            r_state <= S_WAIT;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_CAPTURE: begin
          // r_last still identifies the port that owns this read.
          if (r_last) begin
            r_rdata1  <= ram_rdata;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= ram_rdata;
            r_rvalid0 <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = r_busy;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter for the single-port 64x16 data RAM.
- Port 0 is the CPU load/store path; port 1 is a secondary master such as a program loader or debug/DMA engine.
- Serialises accesses with a req/gnt handshake and round-robin fairness.
- Drives the RAM enable, write-enable, address and write-data pins, and returns read data per port with a valid pulse.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 16, RAM data width.
- READ_LAT, 1, RAM read latency in cycles from enable to valid ram_rdata (1..3 supported).

Ports:
- clk_main  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- rvalid0  out  1  one-cycle pulse: rdata0 valid.
- rdata0  out  DATA_W  port 0 read data; held until the next port 0 read completes.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; every output 0; rdata0/rdata1 = 0; last_served = 1, so port 0 wins the first tie.
- States: IDLE, ACCESS, WAIT, CAPTURE.
- IDLE:
  - No req: stay in IDLE.
  - One req: that port wins.
  - Both req: port != last_served wins.
  - On a winner: latch its we/addr/wdata into the RAM output registers, set last_served = winner, pulse gnt_winner next cycle, go to ACCESS.
- ACCESS (one cycle):
  - ram_en = 1, ram_we = latched we, ram_addr/ram_wdata = latched values.
  - Write: next state IDLE.
  - Read: next state WAIT if READ_LAT > 1, else CAPTURE.
- WAIT: counter runs READ_LAT-1 cycles with ram_en = 0, then goes to CAPTURE.
- CAPTURE:
  - Register ram_rdata into rdata_winner.
  - rvalid_winner pulses in the following cycle.
  - Next state IDLE.
- Latency from the req edge sampled in IDLE:
  - gnt at +1.
  - Write performed at +1; arbiter back in IDLE at +2.
  - Read: rvalid at +2+READ_LAT.
- ram_en is high only in ACCESS and ram_we only in ACCESS of a write; both are 0 in every other state.
- ram_addr/ram_wdata hold their last latched value outside ACCESS.
- Requester rules:
  - A req still high in the first IDLE cycle after its gnt counts as a new request.
  - A requester wanting one transaction drops req the cycle after gnt.
  - Requests arriving while busy wait; there is no queue beyond the held req.
- Port-level rules:
  - The non-winning port's req is not dropped; it is granted next IDLE, which gives strict alternation under continuous contention.
  - gnt0 and gnt1 are never high together; likewise rvalid0 and rvalid1.
  - A write never raises rvalid.
- Reset mid-operation: transaction aborted; ram_en/ram_we drop asynchronously; no gnt/rvalid is issued for it; rdata cleared.
- Address arithmetic: none; addresses pass through unmodified. No wrap logic in the arbiter; address 63 is valid.

Test Plan:
- Single write: req0=1, we0=1, addr0=6'h05, wdata0=16'hBEEF in IDLE.
  - Required: gnt0 at +1; same cycle ram_en=1, ram_we=1, ram_addr=05, ram_wdata=BEEF; busy low at +2; no rvalid.
- Single read (READ_LAT=1, model RAM holding BEEF at 05): req1=1, we1=0, addr1=05.
  - Required: gnt1 at +1; rvalid1 at +3 with rdata1=16'hBEEF; rdata1 holds BEEF afterwards.
- Contention: req0 and req1 asserted together from reset, both writes (addr 01/data 1111, addr 02/data 2222), each held until its gnt.
  - Required: port 0 granted first (ram_addr=01), then port 1 (ram_addr=02); no simultaneous gnt.
- Continuous contention: both reqs held high for 8 transactions.
  - Required: grants alternate 0,1,0,1...; each port receives exactly 4.
- Reset mid-read: assert reset during WAIT/CAPTURE of a port 0 read (READ_LAT=2).
  - Required: immediately ram_en=0, busy=0, rdata0=0; no rvalid0 after reset release.
- Boundary address: read addr0=6'h3F after writing 16'h0001 there.
  - Required: ram_addr=3F, rdata0=0001.
